mux_nx1_rr_reg: RTL and testbench
=================================

// Module: mux_nx1_rr_reg
// PURPOSE
//   Parametrised N-input, W-bit registered multiplexer with per-channel valid/ready.
//   Generalises the combinational 4x1 n-bit mux to N channels of width W.
//   Two select modes:
//     - fixed: external select, like the combinational mux.
//     - round-robin: fair arbitration across requesting channels.
//   Selected word lands in a one-entry output register with valid/ready handshake.
//   Sits between multiple producers and one downstream consumer.
// PARAMETERS
//   N     4              number of input channels (>=2)
//   W     4              data width per channel
//   SELW  $clog2(N)      select/channel-index width (derived, do not override)
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high reset
//   in_data    in   N*W     channel i occupies bits [i*W +: W]
//   in_valid   in   N       channel i has a word to offer
//   in_ready   out  N       one-hot (or zero); channel i word accepted this cycle
//   mode       in   1       0 = fixed select via sel, 1 = round-robin
//   sel        in   SELW    channel index used when mode=0
//   out_data   out  W       registered selected word
//   out_sel    out  SELW    index of channel that produced out_data
//   out_valid  out  1       output register holds a word
//   out_ready  in   1       consumer accepts out_data this cycle
// BEHAVIOUR
//   Reset (async, immediate):
//     - out_valid=0, out_data=0, out_sel=0, in_ready=0.
//     - Round-robin pointer last_grant=N-1, so the first search starts at channel 0.
//   load_en = ~out_valid | out_ready (output slot free or draining this cycle).
//   Grant, combinational from current inputs:
//     - mode=0: grant=sel iff sel<N and in_valid[sel]; otherwise no grant.
//       sel>=N never grants.
//     - mode=1: first channel with in_valid set, searching last_grant+1 .. N-1, 0 .. last_grant (wrap).
//   in_ready[i] = load_en & granted & (grant==i). Never more than one bit high.
//   On the clock edge with any in_ready[i]=1:
//     - out_data <= word i, out_sel <= i, out_valid <= 1.
//     - mode=1 only: last_grant <= i.
//   On the edge with out_valid & out_ready and no new grant: out_valid <= 0.
//     - out_data/out_sel hold their last values.
//   Simultaneous drain and load: new word replaces old with no bubble.
//     - Sustained throughput is 1 word/cycle.
//   Latency: accepted word appears on out_data the cycle after its in_ready handshake.
//   Backpressure (out_valid=1, out_ready=0):
//     - in_ready=0 on all channels.
//     - out_data, out_sel, out_valid and last_grant are all stable.
//   Mode and pointer rules:
//     - mode/sel are sampled only when arbitrating; changes never disturb the held word.
//     - last_grant is retained across mode=0 periods; round-robin resumes from it.
//   Single requester in round-robin is granted every cycle regardless of pointer.
//   No requester: no grant, pointer unchanged.
//   Reset asserted mid-transfer discards the held word; no channel sees a handshake that cycle.
// TESTING (N=4, W=4)
//   1. mode=0, in_data={15,11,7,3} (ch3..ch0), all valid, out_ready=1, sel=0,1,2,3 one per cycle
//      -> out_data 3,7,11,15 with out_sel 0..3, each one cycle after the matching in_ready.
//   2. mode=1, all valid, out_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3;
//      out_valid stays high with no bubbles.
//   3. mode=1, in_valid=4'b1010 -> grants alternate 1,3,1,3; ch0 and ch2 in_ready stay 0.
//   4. Word 11 from ch2 loaded, then out_ready=0 for 3 cycles with all valid
//      -> out_data=11 and out_sel=2 hold, in_ready=0; after release, next grant is ch3.
//   5. mode=0, sel=2, in_valid[2]=0 -> no grant, out_valid falls after drain;
//      raise in_valid[2] with word 9 -> out_data=9 next cycle.
//   6. reset pulsed async mid-stream with out_valid=1
//      -> out_valid=0, out_data=0 immediately; first round-robin grant after release is ch0.

Source files
------------

// File: rtl/mux_nx1_rr_reg.sv
// N-input, W-bit registered multiplexer with per-channel valid/ready handshake.
// Two select modes: fixed select (mode=0) or round-robin arbitration (mode=1).
// The selected word is captured in a one-entry output register that drains
// through out_valid/out_ready. A drain and a load can share a cycle, so the
// mux sustains one word per cycle.
module mux_nx1_rr_reg #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [W-1:0]    words [N];
  logic [SELW-1:0] last_grant;
  logic [SELW-1:0] rr_grant;
  logic            rr_found;
  logic            fixed_hit;
  logic [SELW-1:0] grant;
  logic            granted;
  logic            load_en;
  logic            take;
  int unsigned     probe;

  // Split the flat input bus into per-channel words
  for (genvar g = 0; g < N; g++) begin : g_words
    assign words[g] = in_data[g*W +: W];
  end

  // Output slot can accept a word when empty or draining this cycle
  assign load_en = ~out_valid | out_ready;

  // Fixed-select hit: only in-range select values pointing at a valid channel
  assign fixed_hit = (32'(sel) < N) && in_valid[sel];

  // Round-robin search starting just after the last granted channel
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    probe    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      probe = (32'(last_grant) + k) % N;
      if (!rr_found && in_valid[SELW'(probe)]) begin
        rr_found = 1'b1;
        rr_grant = SELW'(probe);
      end
    end
  end

  // Grant selection between fixed and round-robin modes
  always_comb begin
    grant   = '0;
    granted = 1'b0;
    if (mode) begin
      grant   = rr_grant;
      granted = rr_found;
    end else begin
      grant   = sel;
      granted = fixed_hit;
    end
  end

  // One-hot handshake to the granted channel; suppressed while in reset
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = ~reset & load_en & granted & (grant == SELW'(i));
    end
  end

  assign take = |in_ready;

  // Output register: load on handshake, otherwise clear valid on drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else if (take) begin
      out_data  <= words[grant];
      out_sel   <= grant;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer: advances only on round-robin grants, kept across fixed mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= SELW'(N - 1);
    end else if (take && mode) begin
      last_grant <= grant;
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr_reg.sv
// Directed testbench for mux_nx1_rr_reg (N=4, W=4).
module tb_mux_nx1_rr_reg;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 4;
  localparam int unsigned SELW = 2;

  logic            clk;
  logic            reset;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_sel;
  logic            out_valid;
  logic            out_ready;

  int n_cmp;
  int n_err;

  mux_nx1_rr_reg #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_data   = 16'hFB73;
    in_valid  = 4'b1111;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 4'd0) begin n_err++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    n_cmp++; if (out_sel !== 2'd0) begin n_err++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    reset = 1'b0;
  endtask

  // Fixed select sweeps sel 0..3, one word per cycle
  task automatic test_fixed();
    logic [W-1:0] exp_word [4];
    logic [N-1:0] exp_rdy;
    exp_word[0] = 4'd3; exp_word[1] = 4'd7; exp_word[2] = 4'd11; exp_word[3] = 4'd15;
    mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = SELW'(s);
      exp_rdy = 4'b0001 << s;
      #2;
      n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL fixed_in_ready[%0d]: got %b want %b", s, in_ready, exp_rdy); end
      tick();
      n_cmp++; if (out_data !== exp_word[s]) begin n_err++; $display("FAIL fixed_out_data[%0d]: got %0d want %0d", s, out_data, exp_word[s]); end
      n_cmp++; if (out_sel !== SELW'(s)) begin n_err++; $display("FAIL fixed_out_sel[%0d]: got %0d want %0d", s, out_sel, s); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fixed_out_valid[%0d]: got %b want 1", s, out_valid); end
    end
  endtask

  // Round-robin over all channels: 0,1,2,3,0,1,2,3 with no bubbles
  task automatic test_rr_all();
    int g;
    logic [N-1:0] exp_rdy;
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      g = c % 4;
      exp_rdy = 4'b0001 << g;
      #2;
      n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rr_all_in_ready[%0d]: got %b want %b", c, in_ready, exp_rdy); end
      tick();
      n_cmp++; if (out_sel !== SELW'(g)) begin n_err++; $display("FAIL rr_all_out_sel[%0d]: got %0d want %0d", c, out_sel, g); end
      n_cmp++; if (out_data !== W'(4 * g + 3)) begin n_err++; $display("FAIL rr_all_out_data[%0d]: got %0d want %0d", c, out_data, 4 * g + 3); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rr_all_out_valid[%0d]: got %b want 1", c, out_valid); end
    end
  endtask

  // Round-robin with only channels 1 and 3 requesting
  task automatic test_rr_sparse();
    logic [N-1:0] exp_rdy [4];
    exp_rdy[0] = 4'b0010; exp_rdy[1] = 4'b1000; exp_rdy[2] = 4'b0010; exp_rdy[3] = 4'b1000;
    mode     = 1'b1;
    in_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #2;
      n_cmp++; if (in_ready !== exp_rdy[c]) begin n_err++; $display("FAIL rr_sparse_in_ready[%0d]: got %b want %b", c, in_ready, exp_rdy[c]); end
      tick();
    end
    n_cmp++; if (out_sel !== 2'd3) begin n_err++; $display("FAIL rr_sparse_out_sel: got %0d want 3", out_sel); end
  endtask

  // Hold under backpressure, then resume with the next round-robin channel
  task automatic test_backpressure();
    mode      = 1'b1;
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #2;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL bp_load_in_ready: got %b want 0100", in_ready); end
    tick();
    n_cmp++; if (out_data !== 4'd11) begin n_err++; $display("FAIL bp_load_out_data: got %0d want 11", out_data); end
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", c, in_ready); end
      tick();
      n_cmp++; if (out_data !== 4'd11 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold[%0d]: got data=%0d sel=%0d valid=%b want data=11 sel=2 valid=1", c, out_data, out_sel, out_valid);
      end
    end
    out_ready = 1'b1;
    #2;
    n_cmp++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL bp_release_in_ready: got %b want 1000", in_ready); end
    tick();
    n_cmp++; if (out_sel !== 2'd3 || out_data !== 4'd15) begin
      n_err++; $display("FAIL bp_release_out: got sel=%0d data=%0d want sel=3 data=15", out_sel, out_data);
    end
  endtask

  // Fixed select on an idle channel drains, then loads once it requests
  task automatic test_fixed_idle();
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b1011;
    out_ready = 1'b1;
    #2;
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL idle_in_ready: got %b want 0000", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 4'd15 || out_sel !== 2'd3) begin
      n_err++; $display("FAIL idle_hold: got data=%0d sel=%0d want data=15 sel=3", out_data, out_sel);
    end
    in_data  = 16'hF973;
    in_valid = 4'b1111;
    #2;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL idle_wake_in_ready: got %b want 0100", in_ready); end
    tick();
    n_cmp++; if (out_data !== 4'd9 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL idle_wake_out: got data=%0d sel=%0d valid=%b want data=9 sel=2 valid=1", out_data, out_sel, out_valid);
    end
  endtask

  // Async reset mid-stream clears the output and rewinds the pointer
  task automatic test_async_reset();
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_sel !== 2'd0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL areset_pre: got sel=%0d valid=%b want sel=0 valid=1", out_sel, out_valid);
    end
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 4'd0) begin
      n_err++; $display("FAIL areset_immediate: got valid=%b data=%0d want valid=0 data=0", out_valid, out_data);
    end
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL areset_in_ready: got %b want 0000", in_ready); end
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL areset_first_grant: got %b want 0001", in_ready); end
    tick();
    n_cmp++; if (out_sel !== 2'd0 || out_data !== 4'd3) begin
      n_err++; $display("FAIL areset_first_out: got sel=%0d data=%0d want sel=0 data=3", out_sel, out_data);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_fixed_idle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
